// File: rtl/conv_pkg.sv
// Shared types and mode decoders for the convolution datapath (controller and
// operand fetchers decode kernel/stride modes through the same functions).
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  function automatic logic [2:0] kernel_size(input logic [1:0] mode);
    return {mode, 1'b1};
  endfunction

  // Mode 3 is reserved and falls back to unit stride.
  function automatic logic [2:0] stride(input logic [1:0] mode);
    logic [2:0] s;
    case (mode)
      2'd0:    s = 3'd1;
      2'd1:    s = 3'd2;
      2'd2:    s = 3'd4;
      default: s = 3'd1;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/a_skid_fifo.sv
// Two-entry FIFO between the activation memory and the operand consumer.
// A push into a full FIFO is legal only together with a pop.
module a_skid_fifo #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [1:0]       cnt_q;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/a_operand_fetcher.sv
// Activation operand fetcher: walks the conv loop nest, reads (or zero-pads)
// one activation per MAC and streams it out through a 2-entry buffer.
module a_operand_fetcher
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH         = 16,
  parameter int LOG2_OF_MEM_HEIGHT = 20,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int INPUT_NB_CHANNELS  = 64,
  parameter int OUTPUT_NB_CHANNELS = 64
) (
  input  logic                          clk,
  input  logic                          arst_n_in,
  input  logic                          start,
  input  logic [1:0]                    conv_kernel_mode,
  input  logic [1:0]                    conv_stride_mode,
  output logic                          busy,
  output logic                          done,
  output logic                          mem_re,
  output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  output logic                          a_valid,
  input  logic                          a_ready,
  output logic [DATA_WIDTH-1:0]         a_data
);

  localparam int AW  = LOG2_OF_MEM_HEIGHT;
  localparam int XW  = $clog2(FEATURE_MAP_WIDTH + 1);
  localparam int YW  = $clog2(FEATURE_MAP_HEIGHT + 1);
  localparam int CIW = $clog2(INPUT_NB_CHANNELS + 1);
  localparam int COW = $clog2(OUTPUT_NB_CHANNELS + 1);
  localparam logic signed [32:0] W33 = 33'(FEATURE_MAP_WIDTH);
  localparam logic signed [32:0] H33 = 33'(FEATURE_MAP_HEIGHT);

  fetch_state_e   state_q, state_d;
  logic [2:0]     k_q, k_d, s_q, s_d;
  logic [2:0]     kh_q, kh_d, kv_q, kv_d;
  logic [COW-1:0] co_q, co_d;
  logic [CIW-1:0] ci_q, ci_d;
  logic [YW-1:0]  y_q, y_d;
  logic [XW-1:0]  x_q, x_d;
  logic           pend_q, pend_d, pend_mem_q, pend_mem_d;
  logic           done_q, done_d, busy_q;
  logic [AW-1:0]  addr_q;

  logic kh_last_s, kv_last_s, co_last_s, ci_last_s, y_last_s, x_last_s;
  logic c_kv_s, c_co_s, c_ci_s, c_y_s, c_x_s, last_s;
  logic signed [32:0] px_s, py_s;
  logic [2:0]     half_s;
  logic           pad_s, issue_s, credit_ok_s, pop_s, push_s, drain_done_s;
  logic           fifo_full_s, fifo_empty_s;
  logic [1:0]     fifo_cnt_s;
  logic [AW-1:0]  addr_s;
  logic [DATA_WIDTH-1:0] push_data_s;

  assign kh_last_s = (kh_q == k_q - 3'd1);
  assign kv_last_s = (kv_q == k_q - 3'd1);
  assign co_last_s = (32'(co_q) == 32'(OUTPUT_NB_CHANNELS - 1));
  assign ci_last_s = (32'(ci_q) == 32'(INPUT_NB_CHANNELS - 1));
  assign y_last_s  = (32'(y_q) >= 32'(FEATURE_MAP_HEIGHT) - 32'(s_q));
  assign x_last_s  = (32'(x_q) >= 32'(FEATURE_MAP_WIDTH) - 32'(s_q));

  assign c_kv_s = kh_last_s;
  assign c_co_s = c_kv_s & kv_last_s;
  assign c_ci_s = c_co_s & co_last_s;
  assign c_y_s  = c_ci_s & ci_last_s;
  assign c_x_s  = c_y_s & y_last_s;
  assign last_s = c_x_s & x_last_s;

  // Tap position relative to the kernel centre; negative means left/above the image.
  assign half_s = {1'b0, k_q[2:1]};
  assign px_s   = $signed(33'(x_q) + 33'(kh_q) - 33'(half_s));
  assign py_s   = $signed(33'(y_q) + 33'(kv_q) - 33'(half_s));
  assign pad_s  = (px_s < 33'sd0) || (py_s < 33'sd0) || (px_s >= W33) || (py_s >= H33);
  assign addr_s = (AW'(py_s) * AW'(FEATURE_MAP_WIDTH) + AW'(px_s)) * AW'(INPUT_NB_CHANNELS)
                + AW'(ci_q);

  // Credit counts the same-cycle pop so a_ready held high sustains one operand per cycle.
  assign fifo_cnt_s  = fifo_full_s ? 2'd2 : (fifo_empty_s ? 2'd0 : 2'd1);
  assign pop_s       = ~fifo_empty_s & a_ready;
  assign credit_ok_s = ({1'b0, fifo_cnt_s} + {2'b00, pend_q}) < (3'd2 + {2'b00, pop_s});
  assign issue_s     = (state_q == ISSUE) & credit_ok_s;

  // A pad goes straight in unless an earlier request is pushing this cycle.
  assign push_s       = pend_q | (issue_s & pad_s & ~pend_q);
  assign push_data_s  = (pend_q & pend_mem_q) ? mem_rdata : '0;
  assign drain_done_s = ~pend_q & (fifo_cnt_s == {1'b0, pop_s});

  assign mem_re        = issue_s & ~pad_s;
  assign mem_read_addr = mem_re ? addr_s : addr_q;

  // Next-state, loop counters and delayed-push bookkeeping.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    s_d        = s_q;
    kh_d       = kh_q;
    kv_d       = kv_q;
    co_d       = co_q;
    ci_d       = ci_q;
    y_d        = y_q;
    x_d        = x_q;
    pend_d     = 1'b0;
    pend_mem_d = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          k_d     = kernel_size(conv_kernel_mode);
          s_d     = stride(conv_stride_mode);
          kh_d    = 3'd0;
          kv_d    = 3'd0;
          co_d    = '0;
          ci_d    = '0;
          y_d     = '0;
          x_d     = '0;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (issue_s) begin
          pend_d     = pend_q | ~pad_s;
          pend_mem_d = ~pad_s;
          kh_d = kh_last_s ? 3'd0 : kh_q + 3'd1;
          kv_d = c_kv_s ? (kv_last_s ? 3'd0 : kv_q + 3'd1) : kv_q;
          co_d = c_co_s ? (co_last_s ? '0 : co_q + COW'(1)) : co_q;
          ci_d = c_ci_s ? (ci_last_s ? '0 : ci_q + CIW'(1)) : ci_q;
          y_d  = c_y_s ? (y_last_s ? '0 : y_q + YW'(s_q)) : y_q;
          x_d  = c_x_s ? (x_last_s ? '0 : x_q + XW'(s_q)) : x_q;
          state_d = last_s ? DRAIN : ISSUE;
        end else begin
          state_d = ISSUE;
        end
      end
      DRAIN: begin
        if (drain_done_s) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q    <= IDLE;
      k_q        <= 3'd1;
      s_q        <= 3'd1;
      kh_q       <= 3'd0;
      kv_q       <= 3'd0;
      co_q       <= '0;
      ci_q       <= '0;
      y_q        <= '0;
      x_q        <= '0;
      pend_q     <= 1'b0;
      pend_mem_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      s_q        <= s_d;
      kh_q       <= kh_d;
      kv_q       <= kv_d;
      co_q       <= co_d;
      ci_q       <= ci_d;
      y_q        <= y_d;
      x_q        <= x_d;
      pend_q     <= pend_d;
      pend_mem_q <= pend_mem_d;
      done_q     <= done_d;
      busy_q     <= (state_d != IDLE);
      addr_q     <= mem_read_addr;
    end
  end

  a_skid_fifo #(
    .WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (arst_n_in),
    .push_i (push_s),
    .pop_i  (pop_s),
    .data_i (push_data_s),
    .full_o (fifo_full_s),
    .empty_o(fifo_empty_s),
    .head_o (a_data)
  );

  assign a_valid = ~fifo_empty_s;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
